// File: rtl/remote_cmd_queue.sv
// Turns IR decoder key presses into queued game commands: edge-detects rdy,
// maps and de-bounces repeated codes, and buffers results in a show-ahead FIFO.
module remote_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int HOLDOFF = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   input  logic [2:0] buttons,
   input  logic       cmd_pop,
   input  logic       flag_clr,
   output logic       cmd_valid,
   output logic [1:0] cmd_color,
   output logic       cmd_start,
   output logic       full,
   output logic       overflow,
   output logic       bad_code
);

   localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   // Returns {valid, start, color[1:0]}; anything not listed (incl. X/Z) is invalid.
   function automatic logic [3:0] map_code(input logic [2:0] code);
      logic [3:0] m;
      case (code)
         3'b001:  m = 4'b1000;
         3'b010:  m = 4'b1001;
         3'b011:  m = 4'b1010;
         3'b110:  m = 4'b1011;
         3'b100:  m = 4'b1100;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   logic          rdy_d_r;
   logic [2:0]    last_code_r;
   logic [HW-1:0] hold_cnt_r;
   logic [2:0]    mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r, wr_ptr_r;
   logic [AW:0]   count_r;
   logic          cmd_valid_r, cmd_start_r, full_r, overflow_r, bad_code_r;
   logic [1:0]    cmd_color_r;

   logic [3:0]    map_s;
   logic          ev_s, code_ok_s, suppress_s, accept_s, is_full_s;
   logic          pop_en_s, push_en_s, drop_s, bad_s;
   logic [AW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s;
   logic [AW:0]   count_nxt_s;
   logic [2:0]    head_nxt_s;
   logic [HW-1:0] hold_nxt_s;

   // Event qualification, FIFO bookkeeping and next head entry.
   always_comb begin
      map_s        = map_code(buttons);
      ev_s         = rdy & ~rdy_d_r;
      code_ok_s    = map_s[3];
      suppress_s   = (buttons == last_code_r) && (hold_cnt_r < HOLD_MAX);
      accept_s     = ev_s & code_ok_s & ~suppress_s;
      is_full_s    = (count_r == FULL_CNT);
      pop_en_s     = cmd_pop & (count_r != {(AW + 1){1'b0}});
      push_en_s    = accept_s & (~is_full_s | pop_en_s);
      drop_s       = accept_s & is_full_s & ~pop_en_s;
      bad_s        = ev_s & ~code_ok_s;
      rd_ptr_nxt_s = pop_en_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      wr_ptr_nxt_s = push_en_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      case ({push_en_s, pop_en_s})
         2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
         2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
         default: count_nxt_s = count_r;
      endcase
      // A write landing on the new head slot must bypass the memory read.
      if (count_nxt_s == {(AW + 1){1'b0}}) begin
         head_nxt_s = 3'b000;
      end else if (push_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_nxt_s = map_s[2:0];
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
      if (accept_s) begin
         hold_nxt_s = {HW{1'b0}};
      end else if (hold_cnt_r < HOLD_MAX) begin
         hold_nxt_s = hold_cnt_r + HW'(1);
      end else begin
         hold_nxt_s = hold_cnt_r;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_d_r     <= 1'b0;
         last_code_r <= 3'b000;
         hold_cnt_r  <= HOLD_MAX;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 3'b000;
         end
         rd_ptr_r    <= {AW{1'b0}};
         wr_ptr_r    <= {AW{1'b0}};
         count_r     <= {(AW + 1){1'b0}};
         cmd_valid_r <= 1'b0;
         cmd_color_r <= 2'b00;
         cmd_start_r <= 1'b0;
         full_r      <= 1'b0;
         overflow_r  <= 1'b0;
         bad_code_r  <= 1'b0;
      end else begin
         rdy_d_r    <= rdy;
         hold_cnt_r <= hold_nxt_s;
         if (accept_s) begin
            last_code_r <= buttons;
         end else begin
            last_code_r <= last_code_r;
         end
         if (push_en_s) begin
            mem_r[wr_ptr_r] <= map_s[2:0];
         end
         rd_ptr_r    <= rd_ptr_nxt_s;
         wr_ptr_r    <= wr_ptr_nxt_s;
         count_r     <= count_nxt_s;
         cmd_valid_r <= (count_nxt_s != {(AW + 1){1'b0}});
         full_r      <= (count_nxt_s == FULL_CNT);
         cmd_start_r <= head_nxt_s[2];
         cmd_color_r <= head_nxt_s[1:0];
         // Set wins over a coincident clear.
         overflow_r  <= drop_s | (overflow_r & ~flag_clr);
         bad_code_r  <= bad_s  | (bad_code_r & ~flag_clr);
      end
   end

   assign cmd_valid = cmd_valid_r;
   assign cmd_color = cmd_color_r;
   assign cmd_start = cmd_start_r;
   assign full      = full_r;
   assign overflow  = overflow_r;
   assign bad_code  = bad_code_r;

endmodule

// File: tb/tb_remote_cmd_queue.sv
// Directed self-checking bench for remote_cmd_queue (DEPTH=4, HOLDOFF=16).
module tb_remote_cmd_queue;

   logic       clk = 1'b0;
   logic       rst, rdy, cmd_pop, flag_clr;
   logic [2:0] buttons;
   logic       cmd_valid, cmd_start, full, overflow, bad_code;
   logic [1:0] cmd_color;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   remote_cmd_queue #(.DEPTH(4), .AW(2), .HOLDOFF(16)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .buttons(buttons),
      .cmd_pop(cmd_pop), .flag_clr(flag_clr),
      .cmd_valid(cmd_valid), .cmd_color(cmd_color), .cmd_start(cmd_start),
      .full(full), .overflow(overflow), .bad_code(bad_code)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Head is checked as {cmd_valid, cmd_start, cmd_color}.
   task automatic head(input string tag, input logic [3:0] exp);
      chk(tag, {cmd_valid, cmd_start, cmd_color}, exp);
   endtask

   task automatic press(input logic [2:0] code, input int gap);
      buttons = code;
      rdy     = 1'b1;
      cyc(2);
      rdy     = 1'b0;
      cyc(gap - 2);
   endtask

   task automatic pop1();
      cmd_pop = 1'b1;
      cyc(1);
      cmd_pop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b0; cmd_pop = 1'b0; flag_clr = 1'b0; buttons = 3'b000;
      cyc(2);
      head("in_reset_head", 4'b0000);
      rst = 1'b0;
      cyc(1);
      head("reset_head", 4'b0000);
      chk("reset_full", full, 4'd0);
      chk("reset_ovf", overflow, 4'd0);
      chk("reset_bad", bad_code, 4'd0);

      // Long rdy window gives one entry, visible one cycle after the rise.
      buttons = 3'b010; rdy = 1'b1;
      cyc(1);
      head("rise_latency", 4'b1001);
      cyc(3);
      rdy = 1'b0;
      cyc(1);
      pop1();
      head("single_entry", 4'b0000);

      // Four keys fill the FIFO, then drain in order.
      press(3'b001, 40);
      press(3'b011, 40);
      press(3'b110, 40);
      press(3'b100, 40);
      chk("fill_full", full, 4'd1);
      head("fill_h0", 4'b1000);
      pop1(); head("fill_h1", 4'b1010); chk("fill_notfull", full, 4'd0);
      pop1(); head("fill_h2", 4'b1011);
      pop1(); head("fill_h3", 4'b1100);
      pop1(); head("fill_empty", 4'b0000);

      // Same key 10 cycles apart is suppressed.
      cyc(20);
      press(3'b011, 10);
      press(3'b011, 10);
      head("rep10_h0", 4'b1010);
      pop1(); head("rep10_empty", 4'b0000);

      // Same key 20 cycles apart is accepted twice.
      cyc(20);
      press(3'b011, 20);
      press(3'b011, 20);
      head("rep20_h0", 4'b1010);
      pop1(); head("rep20_h1", 4'b1010);
      pop1(); head("rep20_empty", 4'b0000);

      // Different key 10 cycles later is accepted.
      cyc(20);
      press(3'b011, 10);
      press(3'b001, 10);
      head("diff_h0", 4'b1010);
      pop1(); head("diff_h1", 4'b1000);
      pop1(); head("diff_empty", 4'b0000);

      // Overflow with no pop, then push with concurrent pop while full.
      press(3'b010, 4);
      press(3'b011, 4);
      press(3'b110, 4);
      press(3'b100, 4);
      chk("ovf_full", full, 4'd1);
      press(3'b001, 4);
      chk("ovf_set", overflow, 4'd1);
      chk("ovf_still_full", full, 4'd1);
      head("ovf_head", 4'b1001);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("ovf_clr", overflow, 4'd0);
      buttons = 3'b011; rdy = 1'b1; cmd_pop = 1'b1;
      cyc(1);
      cmd_pop = 1'b0;
      chk("pushpop_no_ovf", overflow, 4'd0);
      chk("pushpop_full", full, 4'd1);
      head("pushpop_h0", 4'b1010);
      rdy = 1'b0;
      cyc(1);
      pop1(); head("pushpop_h1", 4'b1011); chk("pushpop_notfull", full, 4'd0);
      pop1(); head("pushpop_h2", 4'b1100);
      pop1(); head("pushpop_tail", 4'b1010);
      pop1(); head("pushpop_empty", 4'b0000);

      // Unmapped codes.
      press(3'b111, 4);
      chk("bad111", bad_code, 4'd1);
      head("bad111_noentry", 4'b0000);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("bad_clr", bad_code, 4'd0);
      press(3'b000, 4);
      chk("bad000", bad_code, 4'd1);
      head("bad000_noentry", 4'b0000);
      buttons = 3'b101; rdy = 1'b1; flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0; rdy = 1'b0;
      chk("bad_set_dominant", bad_code, 4'd1);
      cyc(1);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("bad_clr2", bad_code, 4'd0);

      // Asynchronous reset with entries queued and rdy high across it.
      press(3'b001, 4);
      press(3'b010, 4);
      press(3'b110, 4);
      head("prerst_head", 4'b1000);
      rst = 1'b1; rdy = 1'b1; buttons = 3'b100;
      #1;
      head("async_rst", 4'b0000);
      chk("async_rst_full", full, 4'd0);
      cyc(2);
      head("held_rst", 4'b0000);
      rst = 1'b0;
      cyc(1);
      head("post_rst_ev", 4'b1100);
      cyc(3);
      rdy = 1'b0;
      cyc(1);
      head("post_rst_single", 4'b1100);
      pop1(); head("post_rst_empty", 4'b0000);
      cmd_pop = 1'b1;
      cyc(2);
      cmd_pop = 1'b0;
      head("pop_empty", 4'b0000);
      press(3'b010, 4);
      head("after_empty_pop", 4'b1001);
      pop1(); head("final_empty", 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
